// File: rtl/lvds_frame_scheduler_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lvds_frame_scheduler_if : requester and serializer-side bus of the frame scheduler
// Revision: 1.0
// ---------------------------------------------------------------------------
interface lvds_frame_scheduler_if #(
  parameter int NUM_CHANNELS  = 4,
  parameter int PAYLOAD_BYTES = 3
);
  logic [8*PAYLOAD_BYTES*NUM_CHANNELS-1:0] i_ch_data;
  logic [NUM_CHANNELS-1:0]                 i_ch_valid;
  logic [NUM_CHANNELS-1:0]                 o_ch_ready;
  logic                                    i_data_read;
  logic [8*(PAYLOAD_BYTES+1)-1:0]          o_data;
  logic                                    o_overrun;
  logic [15:0]                             o_frame_count;

  modport master (
    output i_ch_data, i_ch_valid, i_data_read,
    input  o_ch_ready, o_data, o_overrun, o_frame_count
  );

  modport slave (
    input  i_ch_data, i_ch_valid, i_data_read,
    output o_ch_ready, o_data, o_overrun, o_frame_count
  );
endinterface
`default_nettype wire

// File: rtl/lvds_frame_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lvds_frame_scheduler : round-robin arbiter building header+payload frames for an 8b10b serializer
// Revision: 1.0
// ---------------------------------------------------------------------------
module lvds_frame_scheduler #(
  parameter int NUM_CHANNELS  = 4,
  parameter int PAYLOAD_BYTES = 3,
  parameter int HOLD_CYCLES   = 2
) (
  input  wire logic             i_clk,
  input  wire logic             i_reset_n,
  lvds_frame_scheduler_if.slave bus
);

  localparam int c_ptr_w   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int c_sum_w   = c_ptr_w + 2;
  localparam int c_cnt_w   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int c_pl_w    = 8 * PAYLOAD_BYTES;
  localparam int c_frame_w = 8 * (PAYLOAD_BYTES + 1);

  localparam logic [c_sum_w-1:0]      c_num_ch    = c_sum_w'(NUM_CHANNELS);
  localparam logic [c_cnt_w-1:0]      c_hold_init = c_cnt_w'(HOLD_CYCLES - 1);
  localparam logic [c_cnt_w-1:0]      c_cnt_one   = c_cnt_w'(1);
  localparam logic [NUM_CHANNELS-1:0] c_one_hot0  = NUM_CHANNELS'(1);

  typedef enum logic [1:0] {
    S_SELECT  = 2'd0,
    S_PRESENT = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [c_ptr_w-1:0]     ptr_q, ptr_d;
  logic [2:0]             seq_q, seq_d;
  logic [c_frame_w-1:0]   data_q, data_d;
  logic                   overrun_q, overrun_d;
  logic [15:0]            frame_count_q, frame_count_d;
  logic [c_cnt_w-1:0]     hold_cnt_q, hold_cnt_d;

  logic [c_ptr_w:0]             w_start;
  logic [2*NUM_CHANNELS-1:0]    w_valid_dbl;
  logic [NUM_CHANNELS-1:0]      w_rot;
  logic [c_sum_w-1:0]           w_sum;
  logic                         w_found;
  logic [c_ptr_w-1:0]           w_grant;
  logic [c_pl_w-1:0]            w_payload;
  logic [7:0]                   w_header;

  // Rotate the valid vector so bit 0 is the channel just after the pointer.
  assign w_start     = {1'b0, ptr_q} + {{c_ptr_w{1'b0}}, 1'b1};
  assign w_valid_dbl = {bus.i_ch_valid, bus.i_ch_valid} >> w_start;
  assign w_rot       = w_valid_dbl[NUM_CHANNELS-1:0];

  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_sum   = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, w_start} + c_sum_w'(i);
        w_grant = (w_sum >= c_num_ch) ? c_ptr_w'(w_sum - c_num_ch) : c_ptr_w'(w_sum);
      end
    end
  end

  assign w_payload = w_found ? bus.i_ch_data[int'(w_grant)*c_pl_w +: c_pl_w] : '0;
  assign w_header  = w_found ? {1'b1, seq_q, 4'(w_grant)} : {1'b0, seq_q, 4'b0000};

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    seq_d         = seq_q;
    data_d        = data_q;
    overrun_d     = overrun_q;
    frame_count_d = frame_count_q;
    hold_cnt_d    = hold_cnt_q;
    case (state_q)
      S_SELECT: begin
        data_d = {w_payload, w_header};
        seq_d  = seq_q + 3'd1;
        if (w_found) ptr_d = w_grant;
        if (bus.i_data_read) begin
          // Strobe landed before the frame was ready: count it as consumed.
          overrun_d     = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
          hold_cnt_d    = c_hold_init;
          state_d       = S_HOLD;
        end else begin
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (bus.i_data_read) begin
          frame_count_d = frame_count_q + 16'd1;
          hold_cnt_d    = c_hold_init;
          state_d       = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.i_data_read) overrun_d = 1'b1;
        if (hold_cnt_q == '0) state_d = S_SELECT;
        else                  hold_cnt_d = hold_cnt_q - c_cnt_one;
      end
      default: state_d = S_SELECT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= S_SELECT;
      ptr_q         <= c_ptr_w'(NUM_CHANNELS - 1);
      seq_q         <= 3'd0;
      data_q        <= '0;
      overrun_q     <= 1'b0;
      frame_count_q <= 16'd0;
      hold_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      seq_q         <= seq_d;
      data_q        <= data_d;
      overrun_q     <= overrun_d;
      frame_count_q <= frame_count_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

  // The grant is a same-cycle handshake, so it stays combinational; reset masks it.
  assign bus.o_ch_ready    = (i_reset_n && state_q == S_SELECT && w_found) ? (c_one_hot0 << w_grant) : '0;
  assign bus.o_data        = data_q;
  assign bus.o_overrun     = overrun_q;
  assign bus.o_frame_count = frame_count_q;

endmodule
`default_nettype wire
